// File: rtl/sd_pattern_tx.sv
// sd_pattern_tx: serial pattern transmitter.
// Accepts a pattern via valid/ready and shifts it out MSB-first on x, one bit
// per clock, repeating it in_repeat extra times with GAP idle cycles between
// repetitions. x, x_valid and done are registered; in_ready/busy decode state.
module sd_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [$clog2(WIDTH+1)-1:0]   in_len,
  input  logic [3:0]                   in_repeat,
  output logic                         x,
  output logic                         x_valid,
  output logic                         busy,
  output logic                         done
);

  localparam int LW       = $clog2(WIDTH + 1);
  localparam int CW       = $clog2(WIDTH);
  localparam int GW       = (GAP < 2) ? 1 : $clog2(GAP + 1);
  // Gap counter counts GAP-1 down to 0; unused (state never reached) when GAP=0
  localparam int GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] pat_reg;
  logic [LW-1:0]    len_reg;
  logic [CW-1:0]    cnt_reg;
  logic [3:0]       rep_reg;
  logic [GW-1:0]    gap_cnt_reg;
  logic [LW-1:0]    eff_len;
  logic [CW-1:0]    eff_last;
  logic [CW-1:0]    len_last;

  // Clamp the requested length to WIDTH and precompute the index of the first bit
  always_comb begin
    eff_len  = (in_len > LW'(WIDTH)) ? LW'(WIDTH) : in_len;
    eff_last = (eff_len == '0) ? '0 : CW'(eff_len - 1'b1);
    len_last = (len_reg == '0) ? '0 : CW'(len_reg - 1'b1);
  end

  assign in_ready = (state_reg == S_IDLE);
  assign busy     = (state_reg != S_IDLE);

  // Main sequencer: accept request, shift bits, handle repeats and gaps
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_reg   <= S_IDLE;
      pat_reg     <= '0;
      len_reg     <= '0;
      cnt_reg     <= '0;
      rep_reg     <= '0;
      gap_cnt_reg <= '0;
      x           <= 1'b0;
      x_valid     <= 1'b0;
      done        <= 1'b0;
    end else begin
      x       <= 1'b0;
      x_valid <= 1'b0;
      done    <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            pat_reg   <= in_data;
            len_reg   <= eff_len;
            rep_reg   <= in_repeat;
            cnt_reg   <= eff_last;
            state_reg <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (len_reg == '0) begin
            // Zero-length request: nothing to emit, just signal completion
            done      <= 1'b1;
            state_reg <= S_IDLE;
          end else begin
            x       <= pat_reg[cnt_reg];
            x_valid <= 1'b1;
            if (cnt_reg == '0) begin
              if (rep_reg == 4'd0) begin
                done      <= 1'b1;
                state_reg <= S_IDLE;
              end else begin
                rep_reg <= rep_reg - 4'd1;
                if (GAP > 0) begin
                  gap_cnt_reg <= GW'(GAP_LOAD);
                  state_reg   <= S_GAP;
                end else begin
                  cnt_reg <= len_last;
                end
              end
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_reg == '0) begin
            cnt_reg   <= len_last;
            state_reg <= S_SHIFT;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_pattern_tx.sv
// Directed bench for sd_pattern_tx: one DUT with GAP=0, one with GAP=2.
module tb_sd_pattern_tx;

  logic       clk;
  logic       areset;
  logic       in_valid0, in_valid2;
  logic [7:0] in_data;
  logic [3:0] in_len;
  logic [3:0] in_repeat;
  logic       rdy0, x0, xv0, busy0, done0;
  logic       rdy2, x2, xv2, busy2, done2;

  int checks = 0;
  int errors = 0;

  logic cap_x    [0:31];
  logic cap_v    [0:31];
  logic cap_d    [0:31];
  logic cap_rdy  [0:31];
  logic cap_busy [0:31];

  sd_pattern_tx #(.WIDTH(8), .GAP(0)) dut0 (
    .clk(clk), .areset(areset), .in_valid(in_valid0), .in_ready(rdy0),
    .in_data(in_data), .in_len(in_len), .in_repeat(in_repeat),
    .x(x0), .x_valid(xv0), .busy(busy0), .done(done0)
  );

  sd_pattern_tx #(.WIDTH(8), .GAP(2)) dut2 (
    .clk(clk), .areset(areset), .in_valid(in_valid2), .in_ready(rdy2),
    .in_data(in_data), .in_len(in_len), .in_repeat(in_repeat),
    .x(x2), .x_valid(xv2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Record outputs of the selected DUT into slot i
  task automatic record(input int i, input bit use_gap);
    cap_x[i]    = use_gap ? x2    : x0;
    cap_v[i]    = use_gap ? xv2   : xv0;
    cap_d[i]    = use_gap ? done2 : done0;
    cap_rdy[i]  = use_gap ? rdy2  : rdy0;
    cap_busy[i] = use_gap ? busy2 : busy0;
  endtask

  // Present one request (accepted at edge k) and record cycles k+1..k+ncyc
  task automatic run_req(input logic [7:0] d, input logic [3:0] len,
                         input logic [3:0] rep, input bit use_gap, input int ncyc);
    in_data   = d;
    in_len    = len;
    in_repeat = rep;
    if (use_gap) in_valid2 = 1'b1; else in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    in_valid2 = 1'b0;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk); #1;
      record(i, use_gap);
    end
  endtask

  // Count 1011 occurrences in the recorded valid bit stream, overlap allowed
  function automatic int count_1011(input int ncyc);
    logic [3:0] sh;
    int n;
    sh = 4'b0000;
    n = 0;
    for (int i = 1; i <= ncyc; i++) begin
      if (cap_v[i]) begin
        sh = {sh[2:0], cap_x[i]};
        if (sh == 4'b1011) n++;
      end
    end
    return n;
  endfunction

  task automatic test_reset;
    areset = 1'b0;
    in_valid0 = 1'b1;
    in_valid2 = 1'b1;
    in_data = 8'hFF; in_len = 4'd4; in_repeat = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({x0, xv0, done0, busy0, rdy0} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_dut0: {x,xv,done,busy,rdy}=%b expected 00001", {x0, xv0, done0, busy0, rdy0});
    end
    checks++;
    if ({x2, xv2, done2, busy2, rdy2} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_dut2: {x,xv,done,busy,rdy}=%b expected 00001", {x2, xv2, done2, busy2, rdy2});
    end
    in_valid0 = 1'b0;
    in_valid2 = 1'b0;
    #2 areset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy0 !== 1'b0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy0=%b busy2=%b expected 0 0", busy0, busy2);
    end
    $display("test_reset done");
  endtask

  task automatic check_stream(input string name, input int ncyc,
                              input logic [1:31] ex, input logic [1:31] ev,
                              input logic [1:31] ed);
    for (int i = 1; i <= ncyc; i++) begin
      checks++;
      if (cap_v[i] !== ev[i] || (ev[i] && cap_x[i] !== ex[i]) || cap_d[i] !== ed[i]) begin
        errors++;
        $display("FAIL %s cycle k+%0d: x=%b xv=%b done=%b expected x=%b xv=%b done=%b",
                 name, i, cap_x[i], cap_v[i], cap_d[i], ex[i], ev[i], ed[i]);
      end
    end
  endtask

  task automatic test_basic;
    logic [1:31] ex, ev, ed;
    int n;
    run_req(8'h0B, 4'd4, 4'd0, 1'b0, 6);
    ex = {6'b101100, 25'd0};
    ev = {6'b111100, 25'd0};
    ed = {6'b000100, 25'd0};
    check_stream("basic", 6, ex, ev, ed);
    checks++;
    if (cap_rdy[5] !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready k+5: in_ready=%b expected 1", cap_rdy[5]);
    end
    n = count_1011(6);
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL basic_detect: 1011 count=%0d expected 1", n);
    end
    $display("test_basic done");
  endtask

  task automatic test_repeat;
    logic [1:31] ex, ev, ed;
    int n;
    run_req(8'h0B, 4'd4, 4'd1, 1'b0, 10);
    ex = {10'b1011101100, 21'd0};
    ev = {10'b1111111100, 21'd0};
    ed = {10'b0000000100, 21'd0};
    check_stream("repeat_gap0", 10, ex, ev, ed);
    n = count_1011(10);
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL repeat_detect: 1011 count=%0d expected 2", n);
    end
    $display("test_repeat done");
  endtask

  task automatic test_gap;
    logic [1:31] ex, ev, ed;
    run_req(8'h0B, 4'd4, 4'd1, 1'b1, 12);
    ex = {12'b101100101100, 19'd0};
    ev = {12'b111100111100, 19'd0};
    ed = {12'b000000000100, 19'd0};
    check_stream("repeat_gap2", 12, ex, ev, ed);
    $display("test_gap done");
  endtask

  task automatic test_len_zero;
    logic [1:31] ex, ev, ed;
    run_req(8'hFF, 4'd0, 4'd0, 1'b0, 3);
    ex = 31'd0;
    ev = 31'd0;
    ed = {3'b100, 28'd0};
    check_stream("len_zero", 3, ex, ev, ed);
    checks++;
    if (cap_rdy[1] !== 1'b1) begin
      errors++;
      $display("FAIL len_zero_ready k+1: in_ready=%b expected 1", cap_rdy[1]);
    end
    $display("test_len_zero done");
  endtask

  task automatic test_len_clamp;
    logic [1:31] ex, ev, ed;
    run_req(8'hA5, 4'd15, 4'd0, 1'b0, 10);
    ex = {10'b1010010100, 21'd0};
    ev = {10'b1111111100, 21'd0};
    ed = {10'b0000000100, 21'd0};
    check_stream("len_clamp", 10, ex, ev, ed);
    $display("test_len_clamp done");
  endtask

  // in_valid held high with in_data changing every cycle; len=2
  task automatic test_back_to_back;
    logic [7:0] dat [0:8];
    logic [1:31] ex, ev, ed;
    dat[0] = 8'h02; dat[1] = 8'h01; dat[2] = 8'h03;
    dat[3] = 8'h01; dat[4] = 8'h00; dat[5] = 8'h03;
    dat[6] = 8'h02; dat[7] = 8'h03; dat[8] = 8'h00;
    in_len = 4'd2;
    in_repeat = 4'd0;
    in_data = dat[0];
    in_valid0 = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      @(posedge clk); #1;
      record(e, 1'b0);
      if (e < 8) in_data = dat[e+1];
      else in_valid0 = 1'b0;
    end
    ex = {9'b100010100, 22'd0};
    ev = {9'b110110110, 22'd0};
    ed = {9'b010010010, 22'd0};
    check_stream("back_to_back", 9, ex, ev, ed);
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid;
    logic [1:31] ex, ev, ed;
    bit saw_done;
    in_data = 8'h0D; in_len = 4'd4; in_repeat = 4'd0;
    in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (x0 !== 1'b1 || xv0 !== 1'b1 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: x=%b xv=%b busy=%b expected 1 1 1", x0, xv0, busy0);
    end
    #1 areset = 1'b0;
    #1;
    checks++;
    if (x0 !== 1'b0 || xv0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: x=%b xv=%b busy=%b done=%b expected 0 0 0 0", x0, xv0, busy0, done0);
    end
    saw_done = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done0) saw_done = 1'b1;
    end
    #2 areset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_nodone: done seen=%b expected 0", saw_done);
    end
    run_req(8'h0B, 4'd4, 4'd0, 1'b0, 6);
    ex = {6'b101100, 25'd0};
    ev = {6'b111100, 25'd0};
    ed = {6'b000100, 25'd0};
    check_stream("reset_mid_after", 6, ex, ev, ed);
    $display("test_reset_mid done");
  endtask

  initial begin
    areset = 1'b0;
    in_valid0 = 1'b0;
    in_valid2 = 1'b0;
    in_data = '0;
    in_len = '0;
    in_repeat = '0;
    test_reset();
    test_basic();
    test_repeat();
    test_gap();
    test_len_zero();
    test_len_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
